smart_home_scheduler: RTL and testbench

SMART_HOME_SCHEDULER -- requirements
Module: smart_home_scheduler

---
 rtl/smart_home_scheduler.sv | 160 ++++++++++++++++
 tb/tb_smart_home_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_home_scheduler.sv
// Smart home event scheduler: prioritised sensor service with dwell,
// fire preemption and hysteretic heater/cooler control when quiet.
module smart_home_scheduler #(
  parameter int DWELL  = 8,
  parameter int T_LOW  = 50,
  parameter int T_HIGH = 70,
  parameter int HYST   = 2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       SFA,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic [6:0] ST,
  output logic       alarmbuzz,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    C_FIRE,
    C_FRONT,
    C_REAR,
    C_WIN
  } cur_t;

  localparam logic [7:0] RELOAD   = 8'(DWELL - 1);
  localparam logic [6:0] HEAT_ON  = 7'(T_LOW);
  localparam logic [6:0] HEAT_OFF = 7'(T_LOW + HYST);
  localparam logic [6:0] COOL_ON  = 7'(T_HIGH);
  localparam logic [6:0] COOL_OFF = 7'(T_HIGH - HYST);

  state_t     state, state_n;
  cur_t       cur, cur_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] sens, clr, pend_n;
  logic       heat_req, cool_req;
  logic       heat_n, cool_n;
  logic       serve_n, quiet_n;
  logic [2:0] disp_n;

  assign sens = {SW, SRD, SFD, SFA};
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          state_n = SERVE;
          cnt_n   = RELOAD;
          priority case (1'b1)
            pending[0]: cur_n = C_FIRE;
            pending[1]: cur_n = C_FRONT;
            pending[2]: cur_n = C_REAR;
            default:    cur_n = C_WIN;
          endcase
        end
      end
      SERVE: begin
        if (cur != C_FIRE && pending[0]) begin
          cur_n = C_FIRE;
          cnt_n = RELOAD;
        end else if (cur == C_FIRE && SFA) begin
          cnt_n = RELOAD;
        end else if (cnt == 8'd0) begin
          state_n = GAP;
          clr     = 4'(1) << cur;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a sensor still high on the closing edge re-latches its request
    pend_n = (pending & ~clr) | sens;
  end

  always_comb begin
    heat_n = heat_req;
    if (ST < HEAT_ON)
      heat_n = 1'b1;
    else if (ST >= HEAT_OFF)
      heat_n = 1'b0;
    cool_n = cool_req;
    if (ST > COOL_ON)
      cool_n = 1'b1;
    else if (ST <= COOL_OFF)
      cool_n = 1'b0;
  end

  always_comb begin
    serve_n = (state_n == SERVE);
    quiet_n = (state_n == IDLE) && (pend_n == 4'd0);
    disp_n  = 3'b000;
    if (serve_n) begin
      unique case (cur_n)
        C_FIRE:  disp_n = 3'b011;
        C_FRONT: disp_n = 3'b001;
        C_REAR:  disp_n = 3'b010;
        C_WIN:   disp_n = 3'b100;
        default: disp_n = 3'b000;
      endcase
    end else if (quiet_n && heat_req) begin
      disp_n = 3'b101;
    end else if (quiet_n && cool_req) begin
      disp_n = 3'b110;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      cur       <= C_FIRE;
      cnt       <= '0;
      pending   <= '0;
      heat_req  <= 1'b0;
      cool_req  <= 1'b0;
      alarmbuzz <= 1'b0;
      fdoor     <= 1'b0;
      rdoor     <= 1'b0;
      winbuzz   <= 1'b0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
      display   <= '0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      cnt       <= cnt_n;
      pending   <= pend_n;
      heat_req  <= heat_n;
      cool_req  <= cool_n;
      alarmbuzz <= serve_n && (cur_n == C_FIRE);
      fdoor     <= serve_n && (cur_n == C_FRONT);
      rdoor     <= serve_n && (cur_n == C_REAR);
      winbuzz   <= serve_n && (cur_n == C_WIN);
      heater    <= quiet_n && heat_req;
      cooler    <= quiet_n && cool_req;
      display   <= disp_n;
    end
  end

endmodule

// File: tb/tb_smart_home_scheduler.sv
// Bench for smart_home_scheduler: cycle model keyed on absolute
// service end times, plus directed literal checks.
module tb_smart_home_scheduler;

  localparam int DW = 8;

  logic       clk;
  logic       rst;
  logic       sfa, sfd, srd, sw;
  logic [6:0] st;
  logic       alarmbuzz, fdoor, rdoor, winbuzz;
  logic       heater, cooler, busy;
  logic [2:0] display;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  smart_home_scheduler #(
    .DWELL (DW),
    .T_LOW (50),
    .T_HIGH(70),
    .HYST  (2)
  ) dut (
    .clk      (clk),
    .Rst      (rst),
    .SFA      (sfa),
    .SFD      (sfd),
    .SRD      (srd),
    .SW       (sw),
    .ST       (st),
    .alarmbuzz(alarmbuzz),
    .fdoor    (fdoor),
    .rdoor    (rdoor),
    .winbuzz  (winbuzz),
    .heater   (heater),
    .cooler   (cooler),
    .display  (display),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0 idle, 1 serving, 2 gap; who 0 fire..3 window
  int        cyc = 0;
  int        m_mode = 0;
  int        m_who = 0;
  int        m_end = 0;
  bit [3:0]  m_pend = '0;
  bit        m_heat = 0;
  bit        m_cool = 0;
  bit [13:0] exp_v;

  task automatic model_step();
    bit [3:0] s;
    bit [3:0] old;
    bit       oh, oc, q;
    bit [3:0] act;
    bit [2:0] d;
    int       t;
    s   = {sw, srd, sfd, sfa};
    old = m_pend;
    oh  = m_heat;
    oc  = m_cool;
    cyc++;
    if (rst) begin
      m_mode = 0; m_who = 0; m_pend = '0;
      m_heat = 0; m_cool = 0; exp_v = '0;
      return;
    end
    t = int'(st);
    if (t < 50) m_heat = 1;
    else if (t >= 52) m_heat = 0;
    if (t > 70) m_cool = 1;
    else if (t <= 68) m_cool = 0;
    if (m_mode == 0) begin
      if (old != 0) begin
        m_mode = 1;
        m_end  = cyc + DW;
        for (int i = 3; i >= 0; i--)
          if (old[i]) m_who = i;
      end
    end else if (m_mode == 1) begin
      if (m_who != 0 && old[0]) begin
        m_who = 0;
        m_end = cyc + DW;
      end else if (m_who == 0 && s[0]) begin
        m_end = cyc + DW;
      end else if (cyc == m_end) begin
        m_mode = 2;
        m_pend[m_who] = 0;
      end
    end else begin
      m_mode = 0;
    end
    m_pend = m_pend | s;
    act = '0;
    d   = 3'b000;
    q   = (m_mode == 0) && (m_pend == 0);
    if (m_mode == 1) begin
      act[m_who] = 1;
      case (m_who)
        0: d = 3'b011;
        1: d = 3'b001;
        2: d = 3'b010;
        default: d = 3'b100;
      endcase
    end else if (q && oh) d = 3'b101;
    else if (q && oc) d = 3'b110;
    exp_v = {act[0], act[1], act[2], act[3],
             q & oh, q & oc, d, m_pend,
             m_mode != 0};
  endtask

  function automatic bit [13:0] dut_v();
    return {alarmbuzz, fdoor, rdoor, winbuzz,
            heater, cooler, display, pending, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    checks++;
    if (dut_v() !== exp_v) begin
      errors++;
      $display("FAIL cycle%0d outputs got %b want %b",
               cyc, dut_v(), exp_v);
    end
  endtask

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  int         n1, n2;
  logic [6:0] hv, cv;
  int         ramp [7] = '{45, 51, 52, 60, 71, 69, 68};

  initial begin
    rst = 1; sfa = 0; sfd = 0; srd = 0; sw = 0;
    st = 7'd40;
    tick(); tick();
    chk("reset_bundle", int'(dut_v()), 0);
    rst = 0;
    tick();
    chk("heat_post_reset1", int'(heater), 0);
    tick();
    chk("heat_post_reset2", int'(heater), 1);
    chk("heat_display", int'(display), 5);
    st = 7'd60;
    repeat (3) tick();

    hv = '0; cv = '0;
    for (int i = 0; i < 7; i++) begin
      st = 7'(ramp[i]);
      tick();
      if (i > 0) begin
        hv[i-1] = heater;
        cv[i-1] = cooler;
      end
    end
    st = 7'd60;
    tick();
    hv[6] = heater;
    cv[6] = cooler;
    chk("ramp_heater", int'(hv), 7'b0000011);
    chk("ramp_cooler", int'(cv), 7'b0110000);
    repeat (2) tick();

    sfd = 1; tick(); sfd = 0;
    chk("fd_pend", int'(pending), 4'b0010);
    chk("fd_latency", int'(fdoor), 0);
    n1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fdoor && display == 3'b001) n1++;
      if (i == 8)
        chk("fd_gap", int'({busy, display, pending, fdoor}),
            9'b1_000_0000_0);
    end
    chk("fd_len", n1, 8);

    srd = 1; sw = 1; tick(); srd = 0; sw = 0;
    chk("rw_pend0", int'(pending), 4'b1100);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      n1 += int'(rdoor);
      n2 += int'(winbuzz);
      if (i == 8) chk("rw_pend1", int'(pending), 4'b1000);
      if (i == 18) chk("rw_pend2", int'(pending), 4'b0000);
    end
    chk("rw_rear_len", n1, 8);
    chk("rw_win_len", n2, 8);

    sw = 1; tick(); sw = 0;
    repeat (3) tick();
    sfa = 1; tick(); sfa = 0;
    tick();
    chk("pre_alarm", int'(alarmbuzz), 1);
    chk("pre_display", int'(display), 3);
    chk("pre_win_pend", int'(pending[3]), 1);
    n1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n1 += int'(winbuzz);
    end
    chk("pre_win_again", n1, 8);

    sfa = 1; tick();
    n1 = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      n1 += int'(alarmbuzz);
    end
    sfa = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n1 += int'(alarmbuzz);
    end
    chk("fire_hold_len", n1, 28);

    sfd = 1; tick(); sfd = 0;
    repeat (4) tick();
    rst = 1; tick();
    chk("rst_mid", int'(dut_v()), 0);
    rst = 0;
    n1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n1 += int'(fdoor);
    end
    chk("rst_no_resume", n1, 0);

    sfd = 1;
    repeat (12) tick();
    sfd = 0;
    repeat (25) tick();
    st = 7'd40;
    srd = 1; tick(); srd = 0;
    repeat (15) tick();
    sfa = 1; tick(); sfa = 0;
    repeat (20) tick();
    st = 7'd75;
    repeat (6) tick();
    st = 7'd60;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
